// File: rtl/id_ex_stage_pkg.sv
// ============================================================
// id_ex_stage_pkg : shared pipeline widths, forward selects, bubble control
// Revision: 1.0
// ============================================================
`default_nettype none

package id_ex_stage_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 5;
  localparam int CW_DEF = 16;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_EXM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  localparam logic [CW_DEF-1:0] C_BUBBLE_CTRL = '0;

endpackage

`default_nettype wire

// File: rtl/id_ex_stage_fwd_mux.sv
// ============================================================
// id_ex_stage_fwd_mux : one EX operand bypass mux, EX/MEM over MEM/WB, r0 never bypassed
// Revision: 1.0
// ============================================================
`default_nettype none

module id_ex_stage_fwd_mux
  import id_ex_stage_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic [AW-1:0] src,
  input  logic [DW-1:0] reg_val,
  input  logic          exm_we,
  input  logic [AW-1:0] exm_dst,
  input  logic [DW-1:0] exm_result,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_dst,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] fwd_val,
  output fwd_sel_e      sel
);

  logic w_src_nz;
  assign w_src_nz = (src != '0);

  always_comb begin
    sel     = FWD_REG;
    fwd_val = reg_val;
    if (exm_we && (exm_dst == src) && w_src_nz) begin
      sel     = FWD_EXM;
      fwd_val = exm_result;
    end else if (wb_we && (wb_dst == src) && w_src_nz) begin
      sel     = FWD_WB;
      fwd_val = wb_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================
// id_ex_stage : ID/EX register with operand forwarding and load-use stall.
// Optional macro ID_EX_PERF_EN adds stall/forward event counters.  Revision: 1.0
// ============================================================
`default_nettype none

module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [AW-1:0] id_dst,
  input  logic          id_we,
  input  logic          id_ld,
  input  logic [CW-1:0] id_ctrl,
  input  logic          flush_i,
  input  logic          hold_i,
  input  logic          exm_we,
  input  logic [AW-1:0] exm_dst,
  input  logic [DW-1:0] exm_result,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_dst,
  input  logic [DW-1:0] wb_data,
  output logic          stall_o,
  output logic          ex_valid,
  output logic [DW-1:0] ex_opa,
  output logic [DW-1:0] ex_opb,
  output logic [DW-1:0] ex_imm,
  output logic [AW-1:0] ex_dst,
  output logic          ex_we,
  output logic          ex_ld,
  output logic [CW-1:0] ex_ctrl
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]   perf_stall_cnt,
  output logic [31:0]   perf_fwd_cnt
`endif
);

  logic          r_valid;
  logic [AW-1:0] r_rs;
  logic [AW-1:0] r_rt;
  logic [DW-1:0] r_opa;
  logic [DW-1:0] r_opb;
  logic [DW-1:0] r_imm;
  logic [AW-1:0] r_dst;
  logic          r_we;
  logic          r_ld;
  logic [CW-1:0] r_ctrl;

  logic [DW-1:0] w_opa;
  logic [DW-1:0] w_opb;
  fwd_sel_e      w_sel_a;
  fwd_sel_e      w_sel_b;
  logic          w_lu;

  id_ex_stage_fwd_mux #(.DW(DW), .AW(AW)) u_fwd_a (
    .src        (r_rs),
    .reg_val    (r_opa),
    .exm_we     (exm_we),
    .exm_dst    (exm_dst),
    .exm_result (exm_result),
    .wb_we      (wb_we),
    .wb_dst     (wb_dst),
    .wb_data    (wb_data),
    .fwd_val    (w_opa),
    .sel        (w_sel_a)
  );

  id_ex_stage_fwd_mux #(.DW(DW), .AW(AW)) u_fwd_b (
    .src        (r_rt),
    .reg_val    (r_opb),
    .exm_we     (exm_we),
    .exm_dst    (exm_dst),
    .exm_result (exm_result),
    .wb_we      (wb_we),
    .wb_dst     (wb_dst),
    .wb_data    (wb_data),
    .fwd_val    (w_opb),
    .sel        (w_sel_b)
  );

  assign w_lu = r_valid && r_ld && (r_dst != '0) && id_valid &&
                ((r_dst == id_rs) || (r_dst == id_rt));

  assign stall_o  = hold_i || (w_lu && !flush_i);
  assign ex_valid = r_valid;
  assign ex_opa   = w_opa;
  assign ex_opb   = w_opb;
  assign ex_imm   = r_imm;
  assign ex_dst   = r_dst;
  assign ex_we    = r_valid && r_we;
  assign ex_ld    = r_valid && r_ld;
  assign ex_ctrl  = r_ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_imm   <= '0;
      r_dst   <= '0;
      r_we    <= 1'b0;
      r_ld    <= 1'b0;
      r_ctrl  <= '0;
    end else if (hold_i) begin
      // Capture bypassed values so a producer retiring during the hold is not lost.
      r_opa <= w_opa;
      r_opb <= w_opb;
    end else if (flush_i || w_lu) begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_ld    <= 1'b0;
      r_ctrl  <= CW'(C_BUBBLE_CTRL);
    end else begin
      r_valid <= id_valid;
      r_rs    <= id_rs;
      r_rt    <= id_rt;
      r_opa   <= id_rs_data;
      r_opb   <= id_rt_data;
      r_imm   <= id_imm;
      r_dst   <= id_dst;
      r_we    <= id_we;
      r_ld    <= id_ld;
      r_ctrl  <= id_valid ? id_ctrl : CW'(C_BUBBLE_CTRL);
    end
  end

`ifdef ID_EX_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_fwd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall <= '0;
      r_perf_fwd   <= '0;
    end else begin
      if (w_lu && !hold_i && !flush_i)
        r_perf_stall <= r_perf_stall + 32'd1;
      if (r_valid && ((w_sel_a != FWD_REG) || (w_sel_b != FWD_REG)))
        r_perf_fwd <= r_perf_fwd + 32'd1;
    end
  end

  assign perf_stall_cnt = r_perf_stall;
  assign perf_fwd_cnt   = r_perf_fwd;
`else
  logic w_unused_sel;
  assign w_unused_sel = |{w_sel_a, w_sel_b};
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================
// tb_id_ex_stage : directed vector table plus hand sequences for id_ex_stage
// Revision: 1.0
// ============================================================
`default_nettype none

module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_dst;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_we, id_ld;
  logic [15:0] id_ctrl;
  logic        flush_i, hold_i;
  logic        exm_we;
  logic [4:0]  exm_dst;
  logic [31:0] exm_result;
  logic        wb_we;
  logic [4:0]  wb_dst;
  logic [31:0] wb_data;
  logic        stall_o, ex_valid, ex_we, ex_ld;
  logic [31:0] ex_opa, ex_opb, ex_imm;
  logic [4:0]  ex_dst;
  logic [15:0] ex_ctrl;

  int n_vec = 0;
  int n_mis = 0;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_dst(id_dst), .id_we(id_we), .id_ld(id_ld), .id_ctrl(id_ctrl),
    .flush_i(flush_i), .hold_i(hold_i),
    .exm_we(exm_we), .exm_dst(exm_dst), .exm_result(exm_result),
    .wb_we(wb_we), .wb_dst(wb_dst), .wb_data(wb_data),
    .stall_o(stall_o), .ex_valid(ex_valid), .ex_opa(ex_opa), .ex_opb(ex_opb),
    .ex_imm(ex_imm), .ex_dst(ex_dst), .ex_we(ex_we), .ex_ld(ex_ld),
    .ex_ctrl(ex_ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [4:0]  rs, rt;
    logic [31:0] rsd, rtd, imm;
    logic [4:0]  dst;
    logic        we, ld;
    logic [15:0] ctrl;
    logic        xwe;
    logic [4:0]  xdst;
    logic [31:0] xres;
    logic        wwe;
    logic [4:0]  wdst;
    logic [31:0] wdat;
    logic        e_stall, e_valid;
    logic [31:0] e_opa, e_opb, e_imm;
    logic [4:0]  e_dst;
    logic        e_we, e_ld;
    logic [15:0] e_ctrl;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                          input logic [4:0] dst, input logic we, input logic ld,
                          input logic [15:0] ctrl);
    id_valid = v; id_rs = rs; id_rt = rt; id_rs_data = rsd; id_rt_data = rtd;
    id_imm = imm; id_dst = dst; id_we = we; id_ld = ld; id_ctrl = ctrl;
  endtask

  task automatic set_fwd(input logic xw, input logic [4:0] xd, input logic [31:0] xr,
                         input logic ww, input logic [4:0] wd, input logic [31:0] wdt);
    exm_we = xw; exm_dst = xd; exm_result = xr; wb_we = ww; wb_dst = wd; wb_data = wdt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; hold_i = 1'b0;
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_fwd(0, 0, 0, 0, 0, 0);

    //          vld rs rt rsd        rtd     imm       dst we ld ctrl     xwe xdst xres          wwe wdst wdat          stall vld opa           opb      imm       dst we ld ctrl
    vt[0] = '{1, 1, 2, 32'h100,  32'h200, 32'h10,   3, 1, 0, 16'h00A1, 0, 0, 32'h0,         0, 0, 32'h0,         0, 1, 32'h100,      32'h200, 32'h10,   3, 1, 0, 16'h00A1};
    vt[1] = '{1, 3, 4, 32'h11,   32'h22,  32'h20,   6, 1, 0, 16'h00B2, 1, 3, 32'hAAAA5555, 1, 3, 32'h1234,      0, 1, 32'hAAAA5555, 32'h22,  32'h20,   6, 1, 0, 16'h00B2};
    vt[2] = '{1, 4, 9, 32'h33,   32'h44,  32'h30,   7, 1, 0, 16'h00C3, 1, 4, 32'h55,        1, 9, 32'h99,        0, 1, 32'h55,       32'h99,  32'h30,   7, 1, 0, 16'h00C3};
    vt[3] = '{1, 0, 0, 32'h0,    32'h5,   32'h40,   2, 1, 0, 16'h00D4, 1, 0, 32'hFFFFFFFF, 1, 0, 32'hFFFF0000, 0, 1, 32'h0,        32'h5,   32'h40,   2, 1, 0, 16'h00D4};
    vt[4] = '{1, 8, 8, 32'h81,   32'h82,  32'h50,   0, 0, 0, 16'h00E5, 0, 8, 32'hDEAD,      0, 8, 32'hBEEF,      0, 1, 32'h81,       32'h82,  32'h50,   0, 0, 0, 16'h00E5};
    vt[5] = '{0, 1, 1, 32'h91,   32'h92,  32'h60,   0, 1, 1, 16'h0000, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 32'h91,       32'h92,  32'h60,   0, 0, 0, 16'h0000};

    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_opa", ex_opa, 32'd0);
    chk("rst_ctrl", {16'd0, ex_ctrl}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive_id(vt[i].vld, vt[i].rs, vt[i].rt, vt[i].rsd, vt[i].rtd, vt[i].imm,
               vt[i].dst, vt[i].we, vt[i].ld, vt[i].ctrl);
      #1;
      chk($sformatf("v%0d_stall", i), {31'd0, stall_o}, {31'd0, vt[i].e_stall});
      tick();
      set_fwd(vt[i].xwe, vt[i].xdst, vt[i].xres, vt[i].wwe, vt[i].wdst, vt[i].wdat);
      #1;
      chk($sformatf("v%0d_valid", i), {31'd0, ex_valid}, {31'd0, vt[i].e_valid});
      chk($sformatf("v%0d_opa", i), ex_opa, vt[i].e_opa);
      chk($sformatf("v%0d_opb", i), ex_opb, vt[i].e_opb);
      chk($sformatf("v%0d_imm", i), ex_imm, vt[i].e_imm);
      chk($sformatf("v%0d_dst", i), {27'd0, ex_dst}, {27'd0, vt[i].e_dst});
      chk($sformatf("v%0d_we", i), {31'd0, ex_we}, {31'd0, vt[i].e_we});
      chk($sformatf("v%0d_ld", i), {31'd0, ex_ld}, {31'd0, vt[i].e_ld});
      chk($sformatf("v%0d_ctrl", i), {16'd0, ex_ctrl}, {16'd0, vt[i].e_ctrl});
    end

    // Load-use: one bubble, then the dependent picks up rt from MEM/WB.
    @(negedge clk);
    set_fwd(0, 0, 0, 0, 0, 0);
    drive_id(1, 1, 2, 32'h1, 32'h2, 32'h0, 5, 1, 1, 16'h000D);
    tick();
    chk("lu_load_ld", {31'd0, ex_ld}, 32'd1);
    drive_id(1, 6, 5, 32'h66, 32'h0, 32'h0, 8, 1, 0, 16'h00E7);
    #1;
    chk("lu_stall", {31'd0, stall_o}, 32'd1);
    tick();
    chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    chk("lu_bubble_ctrl", {16'd0, ex_ctrl}, 32'd0);
    chk("lu_stall_drop", {31'd0, stall_o}, 32'd0);
    tick();
    set_fwd(0, 0, 0, 1, 5, 32'hCAFE);
    #1;
    chk("lu_dep_valid", {31'd0, ex_valid}, 32'd1);
    chk("lu_dep_opb", ex_opb, 32'hCAFE);
    chk("lu_dep_opa", ex_opa, 32'h66);
    chk("lu_dep_ctrl", {16'd0, ex_ctrl}, 32'h00E7);

    // Flush has priority over the load-use stall.
    @(negedge clk);
    set_fwd(0, 0, 0, 0, 0, 0);
    drive_id(1, 1, 2, 32'h1, 32'h2, 32'h0, 5, 1, 1, 16'h000D);
    tick();
    drive_id(1, 5, 3, 32'h0, 32'h0, 32'h0, 8, 1, 0, 16'h00E7);
    flush_i = 1'b1;
    #1;
    chk("fl_stall", {31'd0, stall_o}, 32'd0);
    tick();
    flush_i = 1'b0;
    chk("fl_valid", {31'd0, ex_valid}, 32'd0);
    chk("fl_ctrl", {16'd0, ex_ctrl}, 32'd0);
    chk("fl_we", {31'd0, ex_we}, 32'd0);

    // Hold with a producer retiring only in the first held cycle.
    @(negedge clk);
    drive_id(1, 7, 0, 32'h70, 32'h0, 32'h0, 9, 1, 0, 16'h0011);
    tick();
    drive_id(1, 1, 2, 32'h1, 32'h2, 32'h0, 4, 1, 0, 16'h0022);
    hold_i = 1'b1;
    set_fwd(0, 0, 0, 1, 7, 32'hBEEF);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("hold%0d_opa", c), ex_opa, 32'hBEEF);
      chk($sformatf("hold%0d_stall", c), {31'd0, stall_o}, 32'd1);
      chk($sformatf("hold%0d_ctrl", c), {16'd0, ex_ctrl}, 32'h0011);
      tick();
      set_fwd(0, 0, 0, 0, 0, 0);
    end
    hold_i = 1'b0;
    tick();
    chk("post_hold_ctrl", {16'd0, ex_ctrl}, 32'h0022);

    // Async reset in the middle of a load-use stall.
    @(negedge clk);
    drive_id(1, 1, 2, 32'h1, 32'h2, 32'h3, 5, 1, 1, 16'h000D);
    set_fwd(1, 2, 32'h0, 0, 0, 0);
    tick();
    set_fwd(0, 0, 0, 0, 0, 0);
    drive_id(1, 5, 0, 32'h0, 32'h0, 32'h0, 8, 1, 0, 16'h00E7);
    #1;
    chk("ar_pre_stall", {31'd0, stall_o}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_stall", {31'd0, stall_o}, 32'd0);
    chk("ar_valid", {31'd0, ex_valid}, 32'd0);
    chk("ar_ld", {31'd0, ex_ld}, 32'd0);
    chk("ar_dst", {27'd0, ex_dst}, 32'd0);
    chk("ar_imm", ex_imm, 32'd0);
    chk("ar_ctrl", {16'd0, ex_ctrl}, 32'd0);
    chk("ar_opa", ex_opa, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage pipeline. It sits directly downstream of the GPR read ports.
- Captures the decoded instruction and both GPR read operands, and presents them to the ALU.
- Performs EX-stage operand forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards, asserting a stall and injecting a bubble.

Parameters:
DW, 32, datapath/register width
AW, 5, register index width
CW, 16, opaque decoded control bundle width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_rs  in  AW  source index A (drives GPR ReSel1)
id_rt  in  AW  source index B (drives GPR ReSel2)
id_rs_data  in  DW  GPR DataOut1
id_rt_data  in  DW  GPR DataOut2
id_imm  in  DW  extended immediate
id_dst  in  AW  destination index
id_we  in  1  instruction writes GPR
id_ld  in  1  instruction is a load
id_ctrl  in  CW  ALU/mem control bundle
flush_i  in  1  kill ID instruction (taken branch)
hold_i  in  1  downstream busy; freeze EX
exm_we  in  1  EX/MEM writes GPR
exm_dst  in  AW  EX/MEM destination
exm_result  in  DW  EX/MEM ALU result
wb_we  in  1  MEM/WB writes GPR (= GPR WE)
wb_dst  in  AW  MEM/WB destination (= GPR WeSel)
wb_data  in  DW  MEM/WB data (= GPR WData)
stall_o  out  1  freeze PC and IF/ID this cycle
ex_valid  out  1  EX holds a real instruction
ex_opa  out  DW  forwarded operand A
ex_opb  out  DW  forwarded operand B
ex_imm  out  DW  registered immediate
ex_dst  out  AW  registered destination
ex_we  out  1  ex_valid & registered we
ex_ld  out  1  ex_valid & registered ld
ex_ctrl  out  CW  registered control; all zero when bubble

Behaviour:
- Reset (async, rst_n=0): all registers 0. Resulting outputs: ex_valid=0, ex_we=0, ex_ld=0, ex_dst=0, ex_imm=0, ex_ctrl=0, ex_opa=0, ex_opb=0, stall_o=0.
- Registered state per EX slot: valid, rs, rt, opa_q, opb_q, imm, dst, we, ld, ctrl.
- Forwarding, combinational, applied independently to A (uses rs, opa_q) and B (uses rt, opb_q):
  - Select 1 (EX/MEM): exm_we & exm_dst==src & src!=0. Output exm_result.
  - Else select 2 (MEM/WB): wb_we & wb_dst==src & src!=0. Output wb_data.
  - Else select 0: output registered operand.
  - Register 0 is never forwarded. EX/MEM has priority over MEM/WB.
- Load-use hazard: lu = ex_valid & ex_ld & ex_dst!=0 & id_valid & (ex_dst==id_rs | ex_dst==id_rt).
- stall_o = hold_i | (lu & ~flush_i).
- Clock-edge priority:
  1. hold_i=1: EX slot unchanged, except opa_q/opb_q reload with the current forwarded ex_opa/ex_opb. A held instruction must not lose a producer that retires while it waits.
  2. Else flush_i=1: EX loads a bubble (valid=0, we=0, ld=0, ctrl=0); operands don't-care.
  3. Else lu=1: EX loads a bubble. The ID instruction is held upstream via stall_o. Exactly one bubble per load-use.
  4. Else: EX loads the ID fields, valid=id_valid.
- Latency: ID to EX is 1 cycle. Forward muxes add 0 cycles.
- GPR writes are visible to the ID read in the same cycle, so no WB-to-ID bypass is needed here.
- Reset asserted mid-stall clears everything. stall_o drops immediately.

Optional Feature:
ID_EX_PERF_EN
- Defined: adds outputs perf_stall_cnt and perf_fwd_cnt, each 32 bits, wrapping, reset to 0.
  - perf_stall_cnt increments on each cycle with lu & ~hold_i & ~flush_i.
  - perf_fwd_cnt increments once per cycle when ex_valid and either operand select is nonzero.
- Undefined: ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Shared pipeline package holds: DW/AW defaults, the forward-select encoding (FWD_REG=0, FWD_EXM=1, FWD_WB=2), and the bubble control constant (all-zero CW).
- One natural sub-module, fwd_mux: src index, registered value, EX/MEM triple and MEM/WB triple in; forwarded value and select out. Instantiated twice.

Test Plan:
- Reset: rst_n=0 mid-stream -> all ex_* =0 and stall_o=0 asynchronously, with no clock edge required.
- EX/MEM forward: EX has rs=3, opa_q=0x11; exm_we=1, exm_dst=3, exm_result=0xAAAA5555; wb_we=1, wb_dst=3, wb_data=0x1234 -> ex_opa=0xAAAA5555 (EX/MEM wins).
- r0 guard: rs=0, exm_we=1, exm_dst=0, exm_result=0xFFFFFFFF -> ex_opa=registered 0.
- Load-use: EX holds ld, dst=5; ID has rt=5 -> stall_o=1 for one cycle, next EX valid=0. The cycle after, EX holds the dependent instruction with wb_dst=5, wb_data=0xCAFE -> ex_opb=0xCAFE.
- Flush over load-use: same hazard with flush_i=1 -> stall_o=0, EX bubble, ex_ctrl=0.
- Hold with retiring producer: hold_i=1 for 3 cycles, and wb_we/wb_dst=7/0xBEEF is present only in the first cycle for the EX rs=7 -> ex_opa stays 0xBEEF in all 3 cycles; stall_o=1 throughout.
